// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_pkg
//  Description : Shared constants, default sizes and FSM encoding for the
//                word-array access sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_access_ctrl_pkg;

    localparam int DEF_NUM_WORDS = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_DATA_W    = 8;

    // Polarity of the shared word RW line
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SETUP        = 3'd1,
        ST_ACCESS       = 3'd2,
        ST_CAPTURE      = 3'd3,
        ST_RESP         = 3'd4,
        ST_VERIFY_SETUP = 3'd5,
        ST_VERIFY_READ  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Request/response handshake plus shared word-array bus.
//                master = requester and word array side, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;
    logic [NUM_WORDS-1:0] word_sel;
    logic                 word_rw;
    logic [DATA_W-1:0]    word_din;
    logic [DATA_W-1:0]    word_dout;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, word_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, word_sel, word_rw, word_din
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, word_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, word_sel, word_rw, word_din
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_addr_decoder
//  Description : Combinational word index to one-hot select with range flag.
//                Out-of-range addresses produce an all-zero select.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl_addr_decoder
    import mem_access_ctrl_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  wire logic [ADDR_W-1:0]    addr_i,
    output logic      [NUM_WORDS-1:0] sel_o,
    output logic                      in_range_o
);

    // One comparator per word; an index past NUM_WORDS-1 matches nothing
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_sel
        assign sel_o[gi] = (addr_i == ADDR_W'(gi));
    end

    // Extra bit keeps NUM_WORDS == 2**ADDR_W representable
    assign in_range_o = ({1'b0, addr_i} < (ADDR_W + 1)'(NUM_WORDS));

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Single-request sequencer in front of the word array. Settles
//                RW/data one cycle before asserting the one-hot select, holds
//                them while selected, captures read data, returns a response.
//                Optional macro MEM_WRITE_VERIFY_EN adds a read-back compare
//                after every write.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mem_access_ctrl_if.slave bus
);

    state_t               state_q;
    logic                 write_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;
    logic                 rsp_err_q;
    logic [NUM_WORDS-1:0] word_sel_q;
    logic                 word_rw_q;
    logic [DATA_W-1:0]    word_din_q;

    logic [NUM_WORDS-1:0] w_sel_onehot;
    logic                 w_in_range;

    mem_access_ctrl_addr_decoder #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_dec (
        .addr_i     (addr_q),
        .sel_o      (w_sel_onehot),
        .in_range_o (w_in_range)
    );

    // Sequencer FSM; every bus output is a register updated with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            word_sel_q  <= '0;
            word_rw_q   <= RW_READ;
            word_din_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        word_rw_q   <= bus.req_write ? RW_WRITE : RW_READ;
                        word_din_q  <= bus.req_wdata;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Decoder yields all zeros for an out-of-range index
                    word_sel_q <= w_sel_onehot;
                    state_q    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (write_q) begin
                        word_sel_q <= '0;
                        word_rw_q  <= RW_READ;
`ifdef MEM_WRITE_VERIFY_EN
                        state_q    <= ST_VERIFY_SETUP;
`else
                        rsp_err_q   <= !w_in_range;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
`endif
                    end else begin
                        // Select and read polarity stay put for the capture cycle
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    word_sel_q  <= '0;
                    rsp_rdata_q <= w_in_range ? bus.word_dout : '0;
                    rsp_err_q   <= !w_in_range;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
`ifdef MEM_WRITE_VERIFY_EN
                ST_VERIFY_SETUP: begin
                    word_sel_q <= w_sel_onehot;
                    state_q    <= ST_VERIFY_READ;
                end
                ST_VERIFY_READ: begin
                    // word_din_q still holds the written value
                    word_sel_q  <= '0;
                    rsp_err_q   <= !w_in_range || (bus.word_dout != word_din_q);
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    word_sel_q  <= '0;
                    word_rw_q   <= RW_READ;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.word_sel  = word_sel_q;
    assign bus.word_rw   = word_rw_q;
    assign bus.word_din  = word_din_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl with a six-word
//                array model (addresses 6 and 7 are out of range).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int NW = 6;

`ifdef MEM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WLAT    = VERIFY ? 5 : 3;
    localparam int WSELCYC = VERIFY ? 2 : 1;
    localparam int WPERIOD = VERIFY ? 6 : 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   viol;

    mem_access_ctrl_if #(.NUM_WORDS(NW), .ADDR_W(3), .DATA_W(8)) bus ();

    mem_access_ctrl #(.NUM_WORDS(NW), .ADDR_W(3), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word array model; when verify is built, bit 0 is stuck at zero
    logic [7:0] mem [NW];
    always @(posedge clk) begin
        for (int i = 0; i < NW; i++)
            if (bus.word_sel[i] && !bus.word_rw)
                mem[i] <= VERIFY ? (bus.word_din & 8'hFE) : bus.word_din;
    end

    always_comb begin
        bus.word_dout = 8'h00;
        for (int i = 0; i < NW; i++)
            if (bus.word_sel[i]) bus.word_dout = bus.word_dout | mem[i];
    end

    // Bus protocol watch: select one-hot, RW/din frozen while selected
    logic [NW-1:0] prev_sel;
    logic          prev_rw;
    logic [7:0]    prev_din;
    always @(negedge clk) begin
        if ($countones(bus.word_sel) > 1) viol <= viol + 1;
        else if (prev_sel != '0 && bus.word_sel != '0 &&
                 (bus.word_rw != prev_rw || bus.word_din != prev_din)) viol <= viol + 1;
        prev_sel <= bus.word_sel;
        prev_rw  <= bus.word_rw;
        prev_din <= bus.word_din;
    end

    // Reference contents of the array, updated per completed request
    logic [7:0] ref_mem [8];

    function automatic logic [7:0] stuck(input logic [7:0] x);
        return VERIFY ? (x & 8'hFE) : x;
    endfunction

    function automatic bit werr(input logic [7:0] x);
        return VERIFY && x[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request through the DUT; rsp_ready as currently driven
    task automatic run_txn(input logic w, input logic [2:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rdata, output logic err,
                           output int selcyc, output logic [NW-1:0] selseen,
                           output logic rw_first, output logic [7:0] din_first,
                           output int acc_cyc);
        int guard;
        bit first;
        lat = 0; selcyc = 0; selseen = '0; rw_first = 1'b1; din_first = 8'h00;
        rdata = 8'h00; err = 1'b0; acc_cyc = 0; first = 1'b1;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
        bus.req_wdata = ~d;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.word_sel != '0) begin
                if (first) begin
                    rw_first  = bus.word_rw;
                    din_first = bus.word_din;
                    first     = 1'b0;
                end
                selcyc++;
                selseen |= bus.word_sel;
            end
            if (bus.rsp_valid) begin
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
        if (!bus.rsp_valid) chk("rsp_valid_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         w;
        logic [2:0] a;
        logic [7:0] d;
        int         lat;
        logic [7:0] rdata;
        bit         err;
        logic [NW-1:0] sel;
        int         selcyc;
    } vec_t;

    vec_t vt [10];

    initial begin : watchdog
        #60000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, selcyc, acc1, acc2;
        logic [7:0] rdata, din_first;
        logic err, rw_first;
        logic [NW-1:0] selseen;
        bit stall_bad;
        logic [7:0] held;

        vt[0] = '{1'b1, 3'd2, 8'hA5, WLAT, 8'h00, werr(8'hA5), 6'h04, WSELCYC};
        vt[1] = '{1'b0, 3'd2, 8'h00, 4, stuck(8'hA5), 1'b0, 6'h04, 2};
        vt[2] = '{1'b1, 3'd5, 8'h3C, WLAT, 8'h00, werr(8'h3C), 6'h20, WSELCYC};
        vt[3] = '{1'b0, 3'd5, 8'h00, 4, stuck(8'h3C), 1'b0, 6'h20, 2};
        vt[4] = '{1'b0, 3'd7, 8'h00, 4, 8'h00, 1'b1, 6'h00, 0};
        vt[5] = '{1'b1, 3'd6, 8'hFF, WLAT, 8'h00, 1'b1, 6'h00, 0};
        vt[6] = '{1'b1, 3'd0, 8'h01, WLAT, 8'h00, werr(8'h01), 6'h01, WSELCYC};
        vt[7] = '{1'b1, 3'd0, 8'h00, WLAT, 8'h00, 1'b0, 6'h01, WSELCYC};
        vt[8] = '{1'b0, 3'd0, 8'h00, 4, 8'h00, 1'b0, 6'h01, 2};
        vt[9] = '{1'b0, 3'd6, 8'h00, 4, 8'h00, 1'b1, 6'h00, 0};

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 3'd0;
        bus.req_wdata = 8'h00; bus.rsp_ready = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err",   bus.rsp_err,   0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_word_sel",  bus.word_sel,  0);
        chk("rst_word_rw",   bus.word_rw,   1);
        chk("rst_word_din",  bus.word_din,  0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", bus.req_ready, 1);

        // Give every word a known value
        for (int i = 0; i < NW; i++) begin
            run_txn(1'b1, 3'(i), 8'h10 + 8'(i), lat, rdata, err, selcyc, selseen,
                    rw_first, din_first, acc1);
            chk("init_wr_err", err, 0);
            chk("init_wr_sel", selseen, 1 << i);
            ref_mem[i] = stuck(8'h10 + 8'(i));
        end

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i].w, vt[i].a, vt[i].d, lat, rdata, err, selcyc, selseen,
                    rw_first, din_first, acc1);
            chk($sformatf("vec%0d_lat", i),    lat,     vt[i].lat);
            chk($sformatf("vec%0d_rdata", i),  rdata,   vt[i].rdata);
            chk($sformatf("vec%0d_err", i),    err,     vt[i].err);
            chk($sformatf("vec%0d_sel", i),    selseen, vt[i].sel);
            chk($sformatf("vec%0d_selcyc", i), selcyc,  vt[i].selcyc);
            if (vt[i].sel != '0) begin
                chk($sformatf("vec%0d_rw", i), rw_first, vt[i].w ? 0 : 1);
                if (vt[i].w) chk($sformatf("vec%0d_din", i), din_first, vt[i].d);
            end
            if (vt[i].w && vt[i].a < NW) ref_mem[vt[i].a] = stuck(vt[i].d);
        end

        // Throughput with rsp_ready high
        run_txn(1'b0, 3'd1, 8'h00, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc1);
        run_txn(1'b0, 3'd3, 8'h00, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc2);
        chk("read_period", acc2 - acc1, 5);
        run_txn(1'b1, 3'd1, 8'h42, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc1);
        run_txn(1'b1, 3'd3, 8'h24, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc2);
        chk("write_period", acc2 - acc1, WPERIOD);
        ref_mem[1] = stuck(8'h42);
        ref_mem[3] = stuck(8'h24);

        // Response back-pressure: held response, no accept, stray request ignored
        bus.rsp_ready = 1'b0;
        run_txn(1'b0, 3'd2, 8'h00, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc1);
        chk("stall_lat", lat, 4);
        chk("stall_rdata", rdata, ref_mem[2]);
        held = rdata;
        stall_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd3; bus.req_wdata = 8'hEE;
            if (!bus.rsp_valid || bus.rsp_rdata != held || bus.req_ready || bus.word_sel != '0)
                stall_bad = 1'b1;
        end
        chk("stall_hold", stall_bad, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1'b0, 3'd3, 8'h00, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc1);
        chk("stall_ignored_req", rdata, ref_mem[3]);

        // Reset pulse while the select is up
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd4; bus.req_wdata = 8'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_access_sel", bus.word_sel, 6'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_sel",       bus.word_sel,  0);
        chk("rstmid_rw",        bus.word_rw,   1);
        chk("rstmid_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_req_ready", bus.req_ready, 1);
        run_txn(1'b0, 3'd4, 8'h00, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc1);
        chk("rstmid_no_write", rdata, ref_mem[4]);

        // Randomized requests against the reference array
        for (int n = 0; n < 80; n++) begin
            logic       w;
            logic [2:0] a;
            logic [7:0] d;
            bit         inr;
            w   = 1'($urandom_range(0, 1));
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            inr = (a < NW);
            run_txn(w, a, d, lat, rdata, err, selcyc, selseen, rw_first, din_first, acc1);
            chk("rand_lat",    lat,     w ? WLAT : 4);
            chk("rand_err",    err,     (!inr) || (w && werr(d)));
            chk("rand_rdata",  rdata,   (!w && inr) ? ref_mem[a] : 8'h00);
            chk("rand_sel",    selseen, inr ? (1 << a) : 0);
            chk("rand_selcyc", selcyc,  !inr ? 0 : (w ? WSELCYC : 2));
            if (w && inr) ref_mem[a] = stuck(d);
        end

        chk("bus_protocol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
